// File: rtl/dac_scheduler_if.sv
// Requester and DAC-driver side signals of the DAC scheduler.
// The scheduler uses the master view; requesters and the driver use the slave view.
interface dac_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [8*NUM_REQ-1:0] req_ctrl;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           dac_data;
  logic [7:0]           dac_control;
  logic                 dac_begin;
  logic                 dac_sync;
  logic                 busy;
  logic                 timeout_err;
  logic                 clear_err;

  modport master (
    input  req, req_data, req_ctrl, dac_sync, clear_err,
    output ack, dac_data, dac_control, dac_begin, busy, timeout_err
  );

  modport slave (
    output req, req_data, req_ctrl, dac_sync, clear_err,
    input  ack, dac_data, dac_control, dac_begin, busy, timeout_err
  );
endinterface

// File: rtl/dac_scheduler.sv
// Round-robin sharing of one SPI DAC driver among NUM_REQ requesters.
// Latches the winning word, launches the driver, tracks dac_sync and acks on completion.
module dac_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  dac_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_HIGH,
    S_GAP
  } state_t;

  localparam int unsigned NR  = NUM_REQ;
  localparam int          IW  = $clog2(NUM_REQ);
  localparam int          TW0 = $clog2(TIMEOUT + 1);
  localparam int          TW1 = $clog2(GAP_CYCLES + 1);
  localparam int          TWA = (TW0 > TW1) ? TW0 : TW1;
  localparam int          TW  = (TWA > 6) ? TWA : 6;

  // Timer reads 0 in the first cycle of a state, so the last allowed cycle is N-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = (GAP_CYCLES > 1) ? TW'(GAP_CYCLES - 1) : '0;

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [IW-1:0]      r_rr;
  logic [IW-1:0]      r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic [7:0]         r_data;
  logic [7:0]         r_ctrl;
  logic               r_begin;
  logic               r_busy;
  logic               r_err;

  logic               w_found;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_k;
  logic [7:0]         w_data;
  logic [7:0]         w_ctrl;
  logic               w_tmo;
  logic               w_abort;

  // First pending request at or above the rr pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_k     = '0;
    w_data  = '0;
    w_ctrl  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      w_k = ((32'(r_rr) + i) >= NR) ? IW'(32'(r_rr) + i - NR) : IW'(32'(r_rr) + i);
      if (!w_found && bus.req[w_k]) begin
        w_found = 1'b1;
        w_idx   = w_k;
      end
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (IW'(i) == w_idx) begin
        w_data = bus.req_data[8*i +: 8];
        w_ctrl = bus.req_ctrl[8*i +: 8];
      end
    end
  end

  assign w_tmo   = (r_timer >= TMO_LAST);
  assign w_abort = w_tmo && (((r_state == S_START) && bus.dac_sync) ||
                             ((r_state == S_WAIT_HIGH) && !bus.dac_sync));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_rr    <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_begin <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= '0;
      if (r_timer != '1) r_timer <= r_timer + 1'b1;

      // A new abort outranks a clear in the same cycle.
      if (w_abort)            r_err <= 1'b1;
      else if (bus.clear_err) r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_found && bus.dac_sync) begin
            r_data  <= w_data;
            r_ctrl  <= w_ctrl;
            r_grant <= w_idx;
            r_begin <= 1'b1;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (!bus.dac_sync) begin
            r_begin <= 1'b0;
            r_timer <= '0;
            r_state <= S_WAIT_HIGH;
          end else if (w_tmo) begin
            r_begin <= 1'b0;
            r_timer <= '0;
            r_state <= S_GAP;
          end
        end
        S_WAIT_HIGH: begin
          if (bus.dac_sync) begin
            r_ack[r_grant] <= 1'b1;
            r_rr    <= (r_grant == IW'(NR - 1)) ? '0 : r_grant + 1'b1;
            r_timer <= '0;
            r_state <= S_GAP;
          end else if (w_tmo) begin
            r_timer <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_timer >= GAP_LAST) begin
            r_busy  <= 1'b0;
            r_timer <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.dac_data    = r_data;
  assign bus.dac_control = r_ctrl;
  assign bus.dac_begin   = r_begin;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_err;

endmodule

// File: tb/tb_dac_scheduler.sv
// Directed bench for dac_scheduler with a behavioural 16-bit DAC driver model.
module tb_dac_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  dac_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Driver model: starts on dac_begin while idle, holds sync low for 16 clocks,
  // shifting {control,data} MSB first as seen on the outputs during the shift.
  bit          drv_live   = 1'b1;
  bit          drv_busy   = 1'b0;
  logic [3:0]  drv_bit    = '0;
  logic [15:0] drv_word   = '0;
  logic [15:0] drv_cur;
  int          drv_starts = 0;

  always @(negedge clk) begin
    if (!drv_live) begin
      bus.dac_sync = 1'b1;
      drv_busy     = 1'b0;
    end else if (drv_busy) begin
      drv_cur  = {bus.dac_control, bus.dac_data};
      drv_word = {drv_word[14:0], drv_cur[drv_bit]};
      if (drv_bit == 4'd0) begin
        drv_busy     = 1'b0;
        bus.dac_sync = 1'b1;
      end else begin
        drv_bit = drv_bit - 4'd1;
      end
    end else begin
      bus.dac_sync = 1'b1;
      if (bus.dac_begin === 1'b1) begin
        bus.dac_sync = 1'b0;
        drv_busy     = 1'b1;
        drv_bit      = 4'd15;
        drv_word     = '0;
        drv_starts++;
      end
    end
  end

  // Protocol monitor, sampled 1 time unit after each rising edge.
  int ack_multi = 0;
  int ack_begin = 0;
  int ack_total = 0;
  int gap_run   = 1000;
  int min_gap   = 1000;
  bit prev_begin = 1'b0;

  always @(posedge clk) begin
    #1;
    if ($countones(bus.ack) > 1) ack_multi++;
    if ((bus.ack != '0) && bus.dac_begin) ack_begin++;
    if (bus.ack != '0) ack_total++;
    if (bus.dac_begin && !prev_begin && (gap_run < min_gap)) min_gap = gap_run;
    if (bus.dac_sync && !bus.dac_begin) gap_run++;
    else gap_run = 0;
    prev_begin = bus.dac_begin;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_begin(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.dac_begin === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int limit, input bit drop, output logic [3:0] got);
    got = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.ack !== '0) begin
        got = bus.ack;
        if (drop) bus.req = bus.req & ~bus.ack;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_ctrl  = '0;
    bus.clear_err = 1'b0;
    rst_n         = 1'b0;
    tick(3);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.dac_begin !== 1'b0) begin failures++; $display("FAIL reset_begin got=%0b exp=0", bus.dac_begin); end
    checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
    checks++; if (bus.dac_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.dac_data); end
    checks++; if (bus.dac_control !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", bus.dac_control); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.timeout_err); end
    rst_n = 1'b1;
    tick(2);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_single;
    logic [3:0] got;
    bus.req_data[7:0] = 8'hA5;
    bus.req_ctrl[7:0] = 8'h03;
    bus.req = 4'b0001;
    @(negedge clk);
    checks++; if (bus.dac_begin !== 1'b1) begin failures++; $display("FAIL single_latency got=%0b exp=1", bus.dac_begin); end
    checks++; if ({bus.dac_control, bus.dac_data} !== 16'h03A5) begin failures++; $display("FAIL single_latch got=%h exp=03a5", {bus.dac_control, bus.dac_data}); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b exp=1", bus.busy); end
    wait_ack(100, 1'b1, got);
    checks++; if (got !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", got); end
    checks++; if (drv_word !== 16'h03A5) begin failures++; $display("FAIL single_stream got=%h exp=03a5", drv_word); end
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b1) begin failures++; $display("FAIL single_gap1 ack=%b busy=%0b exp ack=0000 busy=1", bus.ack, bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_gap_end got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got;
    bus.req_data[15:8]  = 8'h11;
    bus.req_ctrl[15:8]  = 8'h21;
    bus.req_data[23:16] = 8'h22;
    bus.req_ctrl[23:16] = 8'h42;
    min_gap = 1000;
    @(negedge clk);
    bus.req = 4'b0110;
    wait_ack(100, 1'b1, got);
    checks++; if (got !== 4'b0010) begin failures++; $display("FAIL b2b_ack1 got=%b exp=0010", got); end
    checks++; if (drv_word !== 16'h2111) begin failures++; $display("FAIL b2b_word1 got=%h exp=2111", drv_word); end
    wait_ack(100, 1'b1, got);
    checks++; if (got !== 4'b0100) begin failures++; $display("FAIL b2b_ack2 got=%b exp=0100", got); end
    checks++; if (drv_word !== 16'h4222) begin failures++; $display("FAIL b2b_word2 got=%h exp=4222", drv_word); end
    checks++; if (min_gap < GAP_CYCLES) begin failures++; $display("FAIL b2b_gap got=%0d exp>=%0d", min_gap, GAP_CYCLES); end
    tick(4);
  endtask

  task automatic test_round_robin;
    logic [3:0]  got;
    logic [3:0]  prev;
    logic [3:0]  exp_ack;
    logic [15:0] exp_word;
    int          starts0;
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_data[8*i +: 8] = 8'hD0 + 8'(i);
      bus.req_ctrl[8*i +: 8] = 8'hC0 + 8'(i);
    end
    starts0 = drv_starts;
    min_gap = 1000;
    prev    = '0;
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_ack  = 4'b0001 << (k % 4);
      exp_word = {8'hC0 + 8'(k % 4), 8'hD0 + 8'(k % 4)};
      wait_ack(100, 1'b0, got);
      if (k == 7) bus.req = '0;
      checks++; if (got !== exp_ack) begin failures++; $display("FAIL rr_order_%0d got=%b exp=%b", k, got, exp_ack); end
      checks++; if (drv_word !== exp_word) begin failures++; $display("FAIL rr_word_%0d got=%h exp=%h", k, drv_word, exp_word); end
      checks++; if (got === prev) begin failures++; $display("FAIL rr_repeat_%0d got=%b prev=%b", k, got, prev); end
      prev = got;
    end
    tick(4);
    checks++; if (drv_starts - starts0 != 8) begin failures++; $display("FAIL rr_starts got=%0d exp=8", drv_starts - starts0); end
    checks++; if (min_gap < GAP_CYCLES) begin failures++; $display("FAIL rr_gap got=%0d exp>=%0d", min_gap, GAP_CYCLES); end
    checks++; if (ack_multi != 0 || ack_begin != 0) begin failures++; $display("FAIL ack_excl multi=%0d with_begin=%0d exp 0/0", ack_multi, ack_begin); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    int acks0;
    drv_live = 1'b0;
    acks0    = ack_total;
    bus.req_data[7:0] = 8'h5F;
    bus.req_ctrl[7:0] = 8'h0F;
    bus.req = 4'b0001;
    wait_begin(10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_begin got=0 exp=1"); end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.dac_begin !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    bus.req = '0;
    checks++; if (n != TIMEOUT) begin failures++; $display("FAIL tmo_begin_cycles got=%0d exp=%0d", n, TIMEOUT); end
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err_set got=%b exp=1", bus.timeout_err); end
    tick(4);
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky got=%b exp=1", bus.timeout_err); end
    checks++; if (ack_total != acks0) begin failures++; $display("FAIL tmo_no_ack got=%0d exp=%0d", ack_total, acks0); end
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", bus.timeout_err); end
    drv_live = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_midflight;
    bit ok;
    int acks0;
    logic [3:0] got;
    bus.req_data[7:0] = 8'h77;
    bus.req_ctrl[7:0] = 8'h07;
    bus.req = 4'b0001;
    wait_begin(10, ok);
    for (int i = 0; i < 10; i++) begin
      if (bus.dac_begin !== 1'b1) break;
      @(negedge clk);
    end
    tick(5);
    acks0 = ack_total;
    rst_n = 1'b0;
    #1;
    checks++; if (!ok || bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0 launched=%0b", bus.busy, ok); end
    checks++; if (bus.dac_begin !== 1'b0) begin failures++; $display("FAIL rstmid_begin got=%0b exp=0", bus.dac_begin); end
    checks++; if ({bus.dac_control, bus.dac_data} !== 16'h0000) begin failures++; $display("FAIL rstmid_bus got=%h exp=0000", {bus.dac_control, bus.dac_data}); end
    checks++; if (bus.ack !== 4'b0000 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rstmid_ack_err ack=%b err=%b exp 0000/0", bus.ack, bus.timeout_err); end
    bus.req = '0;
    tick(2);
    rst_n = 1'b1;
    bus.req_data[31:24] = 8'h5A;
    bus.req_ctrl[31:24] = 8'h81;
    bus.req = 4'b1000;
    wait_ack(200, 1'b1, got);
    checks++; if (got !== 4'b1000) begin failures++; $display("FAIL rstmid_regrant got=%b exp=1000", got); end
    checks++; if (drv_word !== 16'h815A) begin failures++; $display("FAIL rstmid_word got=%h exp=815a", drv_word); end
    checks++; if (ack_total - acks0 != 1) begin failures++; $display("FAIL rstmid_ack_count got=%0d exp=1", ack_total - acks0); end
    tick(4);
  endtask

  task automatic test_data_hold;
    bit ok;
    logic [3:0] got;
    bus.req_data[7:0] = 8'hA5;
    bus.req_ctrl[7:0] = 8'h03;
    bus.req = 4'b0001;
    wait_begin(10, ok);
    @(negedge clk);
    bus.req_data[7:0] = 8'h3C;
    wait_ack(100, 1'b1, got);
    checks++; if (!ok || got !== 4'b0001) begin failures++; $display("FAIL hold_ack got=%b exp=0001 launched=%0b", got, ok); end
    checks++; if (drv_word !== 16'h03A5) begin failures++; $display("FAIL hold_stream got=%h exp=03a5", drv_word); end
    checks++; if (bus.dac_data !== 8'hA5) begin failures++; $display("FAIL hold_data got=%h exp=a5", bus.dac_data); end
    tick(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_timeout();
    test_reset_midflight();
    test_data_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t exp=finish_before_limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
